// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Runs one load or store per request for the 32-bit core. It drives the
//   data-memory bus, builds byte enables, and replicates store data across
//   the byte lanes. Load data is sign- or zero-extended. Completion and any
//   fault are reported through a busy/done handshake.
//
// Ports
//   clk, rst          : system clock; asynchronous active-high reset
//   start             : request strobe, only accepted while idle
//   is_store          : 1 = store, 0 = load
//   mem_ctrl[2:0]     : size code (000 none, 001 sb, 010 sh, 011 w,
//                       100 uh, 101 ub, 11x invalid)
//   addr[31:0]        : byte address from the ALU
//   store_data[31:0]  : store operand
//   bus_req/bus_we    : bus request (held until ack) and write enable
//   bus_addr[31:0]    : word-aligned bus address
//   bus_be[3:0]       : byte enables
//   bus_wdata[31:0]   : lane-replicated store data
//   bus_rdata[31:0]   : read data, valid with bus_ack
//   bus_ack           : bus completion, only honoured while bus_req is high
//   busy              : high whenever a request is in flight
//   done              : one-cycle completion pulse
//   fault[1:0]        : valid with done (00 ok, 01 misaligned, 10 timeout,
//                       11 invalid ctrl)
//   load_data[31:0]   : extended load result, updated on successful loads
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  mem_ctrl,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        busy,
  output logic        done,
  output logic [1:0]  fault,
  output logic [31:0] load_data
);

  // The counter is at least 8 bits wide. It grows only when the timeout
  // needs more range than that.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 256) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  // Value of the counter during the last REQ cycle before a timeout.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              is_store_q, is_store_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [31:0]       bus_addr_q, bus_addr_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [1:0]        fault_q, fault_d;
  logic [31:0]       load_data_q, load_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Decode the incoming request. Signed and unsigned codes share the same
  // size and therefore the same byte enables.
  logic        req_byte, req_half, req_word, req_none, req_invalid, req_misaligned;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;

  always_comb begin
    req_byte       = (mem_ctrl == 3'b001) || (mem_ctrl == 3'b101);
    req_half       = (mem_ctrl == 3'b010) || (mem_ctrl == 3'b100);
    req_word       = (mem_ctrl == 3'b011);
    req_none       = (mem_ctrl == 3'b000);
    req_invalid    = mem_ctrl[2] && mem_ctrl[1];
    req_misaligned = (req_half && addr[0]) || (req_word && (addr[1:0] != 2'b00));
    req_be         = 4'b1111;
    req_wdata      = store_data;
    if (req_byte) begin
      req_be    = 4'b0001 << addr[1:0];
      req_wdata = {4{store_data[7:0]}};
    end else if (req_half) begin
      req_be    = 4'b0011 << addr[1:0];
      req_wdata = {2{store_data[15:0]}};
    end
  end

  // Shift the addressed bytes down to bit 0, then extend them according to
  // the latched size code.
  logic [31:0] rdata_shifted;
  logic [31:0] rdata_fmt;

  always_comb begin
    rdata_shifted = bus_rdata >> {addr_lo_q, 3'b000};
    rdata_fmt     = rdata_shifted;
    case (ctrl_q)
      3'b001:  rdata_fmt = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b010:  rdata_fmt = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b100:  rdata_fmt = {16'h0000, rdata_shifted[15:0]};
      3'b101:  rdata_fmt = {24'h000000, rdata_shifted[7:0]};
      default: rdata_fmt = rdata_shifted;
    endcase
  end

  // Next-state logic. Requests that fault, or that need no access, skip the
  // bus and go straight to DONE. The timeout counter saturates rather than
  // wrapping.
  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    ctrl_d      = ctrl_q;
    addr_lo_d   = addr_lo_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    fault_d     = fault_q;
    load_data_d = load_data_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_store_d = is_store;
          ctrl_d     = mem_ctrl;
          addr_lo_d  = addr[1:0];
          cnt_d      = '0;
          state_d    = S_DONE;
          if (req_invalid) begin
            fault_d = 2'b11;
          end else if (req_none) begin
            fault_d = 2'b00;
          end else if (req_misaligned) begin
            fault_d = 2'b01;
          end else begin
            fault_d     = 2'b00;
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_be_d    = req_be;
            bus_wdata_d = req_wdata;
            state_d     = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (bus_ack) begin
          state_d = S_DONE;
          fault_d = 2'b00;
          if (!is_store_q) begin
            load_data_d = rdata_fmt;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          state_d = S_DONE;
          fault_d = 2'b10;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All state registers. An asynchronous reset returns the unit to idle and
  // clears every bus and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      is_store_q  <= 1'b0;
      ctrl_q      <= 3'b000;
      addr_lo_q   <= 2'b00;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      fault_q     <= 2'b00;
      load_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      ctrl_q      <= ctrl_d;
      addr_lo_q   <= addr_lo_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      fault_q     <= fault_d;
      load_data_q <= load_data_d;
      cnt_q       <= cnt_d;
    end
  end

  // The outputs come straight from the state, so a reset in the middle of a
  // request drops bus_req without waiting for a clock edge.
  assign bus_req   = (state_q == S_REQ);
  assign bus_we    = (state_q == S_REQ) && is_store_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign fault     = (state_q == S_DONE) ? fault_q : 2'b00;
  assign load_data = load_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Directed bench for mem_access_unit with a short timeout of 4 cycles.
//   One linear sequence of steps drives the unit. Its outputs are compared
//   with hand-computed values one cycle at a time.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [2:0]  mem_ctrl;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        busy;
  logic        done;
  logic [1:0]  fault;
  logic [31:0] load_data;

  int checkCount;
  int failCount;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_store   (is_store),
    .mem_ctrl   (mem_ctrl),
    .addr       (addr),
    .store_data (store_data),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .load_data  (load_data)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge. Both stimulus and checks
  // happen at this point, well away from the edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Present a request for a single cycle. The caller lowers start again on
  // the following step.
  task automatic applyStimulus(input logic st, input logic [2:0] ctrl,
                               input logic [31:0] a, input logic [31:0] sd);
    start      = 1'b1;
    is_store   = st;
    mem_ctrl   = ctrl;
    addr       = a;
    store_data = sd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    rst        = 1'b1;
    start      = 1'b0;
    is_store   = 1'b0;
    mem_ctrl   = 3'b000;
    addr       = '0;
    store_data = '0;
    bus_rdata  = '0;
    bus_ack    = 1'b0;

    // Reset values
    #12;
    checkOutput("rst_bus_req",   32'(bus_req),   32'h0);
    checkOutput("rst_bus_we",    32'(bus_we),    32'h0);
    checkOutput("rst_bus_addr",  bus_addr,       32'h0);
    checkOutput("rst_bus_be",    32'(bus_be),    32'h0);
    checkOutput("rst_bus_wdata", bus_wdata,      32'h0);
    checkOutput("rst_busy",      32'(busy),      32'h0);
    checkOutput("rst_done",      32'(done),      32'h0);
    checkOutput("rst_fault",     32'(fault),     32'h0);
    checkOutput("rst_load_data", load_data,      32'h0);
    nextCycle();
    rst = 1'b0;
    nextCycle();

    // Signed byte load at 0x1003; ack arrives in the first REQ cycle
    $display("[TB] load byte signed");
    applyStimulus(1'b0, 3'b001, 32'h0000_1003, 32'h0);
    nextCycle();
    start = 1'b0;
    checkOutput("lb_req",      32'(bus_req), 32'h1);
    checkOutput("lb_we",       32'(bus_we),  32'h0);
    checkOutput("lb_addr",     bus_addr,     32'h0000_1000);
    checkOutput("lb_be",       32'(bus_be),  32'h8);
    checkOutput("lb_busy",     32'(busy),    32'h1);
    checkOutput("lb_done_n1",  32'(done),    32'h0);
    bus_ack   = 1'b1;
    bus_rdata = 32'h80FF_1234;
    nextCycle();
    bus_ack = 1'b0;
    checkOutput("lb_done",     32'(done),    32'h1);
    checkOutput("lb_fault",    32'(fault),   32'h0);
    checkOutput("lb_req_low",  32'(bus_req), 32'h0);
    checkOutput("lb_data",     load_data,    32'hFFFF_FF80);
    nextCycle();
    checkOutput("lb_idle",     32'(busy),    32'h0);
    checkOutput("lb_done_off", 32'(done),    32'h0);

    // Signed half store at 0x2002; three wait cycles, ack on the fourth
    // REQ cycle, which is the last one before the timeout would fire
    $display("[TB] store half with wait states");
    applyStimulus(1'b1, 3'b010, 32'h0000_2002, 32'hDEAD_BEEF);
    nextCycle();
    start = 1'b0;
    checkOutput("sh_req",   32'(bus_req), 32'h1);
    checkOutput("sh_we",    32'(bus_we),  32'h1);
    checkOutput("sh_addr",  bus_addr,     32'h0000_2000);
    checkOutput("sh_be",    32'(bus_be),  32'hC);
    checkOutput("sh_wdata", bus_wdata,    32'hBEEF_BEEF);
    for (int w = 0; w < 3; w++) begin
      nextCycle();
      checkOutput("sh_req_wait", 32'(bus_req), 32'h1);
      checkOutput("sh_be_wait",  32'(bus_be),  32'hC);
    end
    checkOutput("sh_wdata_held", bus_wdata, 32'hBEEF_BEEF);
    bus_ack = 1'b1;
    nextCycle();
    bus_ack = 1'b0;
    checkOutput("sh_done",  32'(done),    32'h1);
    checkOutput("sh_fault", 32'(fault),   32'h0);
    checkOutput("sh_req0",  32'(bus_req), 32'h0);
    checkOutput("sh_we0",   32'(bus_we),  32'h0);
    checkOutput("sh_ld",    load_data,    32'hFFFF_FF80);
    nextCycle();

    // Unsigned byte store at 0x0001
    $display("[TB] store byte unsigned");
    applyStimulus(1'b1, 3'b101, 32'h0000_0001, 32'h1234_56A5);
    nextCycle();
    start = 1'b0;
    checkOutput("sb_be",    32'(bus_be), 32'h2);
    checkOutput("sb_wdata", bus_wdata,   32'hA5A5_A5A5);
    bus_ack = 1'b1;
    nextCycle();
    bus_ack = 1'b0;
    checkOutput("sb_done",  32'(done),   32'h1);
    nextCycle();

    // Misaligned word, then misaligned unsigned half
    $display("[TB] misaligned accesses");
    applyStimulus(1'b0, 3'b011, 32'h0000_3001, 32'h0);
    nextCycle();
    start = 1'b0;
    checkOutput("mw_done",  32'(done),    32'h1);
    checkOutput("mw_fault", 32'(fault),   32'h1);
    checkOutput("mw_req",   32'(bus_req), 32'h0);
    checkOutput("mw_ld",    load_data,    32'hFFFF_FF80);
    nextCycle();
    checkOutput("mw_idle",  32'(busy),    32'h0);
    applyStimulus(1'b0, 3'b100, 32'h0000_3001, 32'h0);
    nextCycle();
    start = 1'b0;
    checkOutput("mh_done",  32'(done),    32'h1);
    checkOutput("mh_fault", 32'(fault),   32'h1);
    checkOutput("mh_req",   32'(bus_req), 32'h0);
    checkOutput("mh_ld",    load_data,    32'hFFFF_FF80);
    nextCycle();

    // Size code none: completes at once, no bus access
    $display("[TB] mem_ctrl none");
    applyStimulus(1'b0, 3'b000, 32'h0000_0004, 32'h0);
    nextCycle();
    start = 1'b0;
    checkOutput("nn_done",  32'(done),    32'h1);
    checkOutput("nn_fault", 32'(fault),   32'h0);
    checkOutput("nn_req",   32'(bus_req), 32'h0);
    checkOutput("nn_ld",    load_data,    32'hFFFF_FF80);
    nextCycle();

    // Timeout: no ack, bus_req high for exactly 4 cycles; a start issued
    // mid-REQ must be dropped
    $display("[TB] timeout");
    applyStimulus(1'b0, 3'b011, 32'h0000_4000, 32'h0);
    nextCycle();
    start = 1'b0;
    checkOutput("to_req1", 32'(bus_req), 32'h1);
    applyStimulus(1'b1, 3'b011, 32'h0000_8000, 32'h5555_5555);
    nextCycle();
    start = 1'b0;
    checkOutput("to_req2", 32'(bus_req), 32'h1);
    checkOutput("to_addr", bus_addr,     32'h0000_4000);
    checkOutput("to_we",   32'(bus_we),  32'h0);
    nextCycle();
    checkOutput("to_req3", 32'(bus_req), 32'h1);
    nextCycle();
    checkOutput("to_req4", 32'(bus_req), 32'h1);
    checkOutput("to_done_early", 32'(done), 32'h0);
    nextCycle();
    checkOutput("to_req5",  32'(bus_req), 32'h0);
    checkOutput("to_done",  32'(done),    32'h1);
    checkOutput("to_fault", 32'(fault),   32'h2);
    checkOutput("to_ld",    load_data,    32'hFFFF_FF80);
    nextCycle();
    checkOutput("to_idle",  32'(busy),    32'h0);

    // Unsigned half load at 0x0002
    $display("[TB] load half unsigned");
    applyStimulus(1'b0, 3'b100, 32'h0000_0002, 32'h0);
    nextCycle();
    start = 1'b0;
    checkOutput("lhu_be",   32'(bus_be), 32'hC);
    bus_ack   = 1'b1;
    bus_rdata = 32'h8001_0000;
    nextCycle();
    bus_ack = 1'b0;
    checkOutput("lhu_done", 32'(done),   32'h1);
    checkOutput("lhu_data", load_data,   32'h0000_8001);
    nextCycle();

    // Asynchronous reset in the middle of REQ
    $display("[TB] async reset mid-request");
    applyStimulus(1'b0, 3'b011, 32'h0000_5000, 32'h0);
    nextCycle();
    start = 1'b0;
    checkOutput("ar_req_before", 32'(bus_req), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("ar_req",  32'(bus_req), 32'h0);
    checkOutput("ar_busy", 32'(busy),    32'h0);
    checkOutput("ar_done", 32'(done),    32'h0);
    checkOutput("ar_ld",   load_data,    32'h0);
    nextCycle();
    rst = 1'b0;
    checkOutput("ar_no_done", 32'(done), 32'h0);
    nextCycle();
    applyStimulus(1'b0, 3'b011, 32'h0000_0000, 32'h0);
    nextCycle();
    start = 1'b0;
    checkOutput("ar_lw_req", 32'(bus_req), 32'h1);
    checkOutput("ar_lw_be",  32'(bus_be),  32'hF);
    bus_ack   = 1'b1;
    bus_rdata = 32'h1234_5678;
    nextCycle();
    bus_ack = 1'b0;
    checkOutput("ar_lw_done",  32'(done),  32'h1);
    checkOutput("ar_lw_fault", 32'(fault), 32'h0);
    checkOutput("ar_lw_data",  load_data,  32'h1234_5678);
    nextCycle();

    // Invalid size code
    $display("[TB] invalid mem_ctrl");
    applyStimulus(1'b1, 3'b111, 32'h0000_0000, 32'h0);
    nextCycle();
    start = 1'b0;
    checkOutput("iv_done",  32'(done),    32'h1);
    checkOutput("iv_fault", 32'(fault),   32'h3);
    checkOutput("iv_req",   32'(bus_req), 32'h0);
    nextCycle();
    checkOutput("iv_idle",  32'(busy),    32'h0);

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule
